// File: rtl/pulse_meter_pkg.sv
// Shared types and helpers for the pulse period meter: FSM state encoding,
// default counter width and the saturation ceiling helper.
package pulse_meter_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    MEASURE    = 2'd2
  } meter_state_e;

  localparam int DEFAULT_CNT_W = 16;

  // All-ones value of a w-bit counter; callers cast it down to their width.
  function automatic logic [31:0] sat_max(input int unsigned w);
    if (w >= 32) return '1;
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/pulse_edge_det.sv
// 1-bit rising-edge detector: rise is high in the first cycle din is high
// after being low. History flop clears on reset.
module pulse_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic din_prev;

  // NOTE: flops use an async active-low reset in the sensitivity list; state is
  // assigned with <= so every flop samples the pre-edge value of its inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) din_prev <= 1'b0;
    else      din_prev <= din;
  end

  assign rise = din & ~din_prev;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures the clk-cycle distance between successive pulse events and
// presents each result on a valid/ready output with saturation and drop flags.
// Define PULSE_PERIOD_METER_EDGE_EN to treat pulse_in as a level (rising edge
// = event); by default every high cycle of pulse_in is an event.
module pulse_period_meter
  import pulse_meter_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             pulse_in,
  input  logic             period_ready,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             ovf,
  output logic             dropped,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

  meter_state_e     state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             pulse_evt;
  logic             capture;

`ifdef PULSE_PERIOD_METER_EDGE_EN
  pulse_edge_det u_edge_det (
    .clk  (clk),
    .rst  (rst),
    .din  (pulse_in),
    .rise (pulse_evt)
  );
`else
  assign pulse_evt = pulse_in;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:       state_nxt = WAIT_FIRST;
        WAIT_FIRST: if (pulse_evt) state_nxt = MEASURE;
        MEASURE:    state_nxt = MEASURE;
        default:    state_nxt = IDLE;
      endcase
    end
  end

  assign capture = enable && (state == MEASURE) && pulse_evt;
  assign busy    = (state != IDLE);

  // cnt holds (cycles since last pulse - 1); it only runs while measuring.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!enable || state != MEASURE || pulse_evt) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // A capture always wins over a transfer; dropped records whether the result
  // being replaced was still waiting for the consumer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period       <= '0;
      period_valid <= 1'b0;
      ovf          <= 1'b0;
      dropped      <= 1'b0;
    end else if (capture) begin
      period       <= (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);
      ovf          <= (cnt == CNT_MAX);
      period_valid <= 1'b1;
      dropped      <= period_valid & ~period_ready;
    end else if (period_valid && period_ready) begin
      period_valid <= 1'b0;
      dropped      <= 1'b0;
    end
  end

endmodule

// File: doc/pulse_period_meter.md
Name: pulse_period_meter

Overview:
Receive-side companion to the tick/pulse counters. Takes a pulse stream generated elsewhere (divider tick, load-compare pulse) and measures the clk-cycle distance between successive pulses. Each measurement is presented on a valid/ready output with saturation and drop flags. Used to check divider ratios on-chip and to feed rate monitors.

Parameters:
CNT_W, 16, width of the interval counter and of period.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
enable  input  1  measurement enable, level
pulse_in  input  1  pulse to be measured; synchronous to clk
period_ready  input  1  consumer accepts period this cycle
period  output  CNT_W  measured interval in clk cycles
period_valid  output  1  period/ovf/dropped hold a result
ovf  output  1  result saturated (interval > 2^CNT_W-1)
dropped  output  1  an unaccepted result was overwritten
busy  output  1  high in WAIT_FIRST or MEASURE

Behaviour:
- Reset (rst=0, async): state IDLE, cnt=0, period=0, period_valid=0, ovf=0, dropped=0, busy=0.
- pulse event: pulse_in==1 in a cycle (see Optional Feature).
- FSM:
  - IDLE: enable=1 -> WAIT_FIRST; a pulse in the same cycle is ignored.
  - WAIT_FIRST: no counting. Pulse -> MEASURE, cnt<=0.
  - MEASURE: no pulse -> cnt<=cnt+1, saturating at 2^CNT_W-1. Pulse -> capture, cnt<=0, stay in MEASURE.
  - enable=0 in any state -> IDLE next edge; cnt<=0; a pending result is retained. A pulse coinciding with enable=0 is not captured.
- Capture rule: pulses at edges t0 and t1 give period = t1-t0. Back-to-back pulses give 1.
  - If cnt == 2^CNT_W-1 at capture: period <= 2^CNT_W-1, ovf<=1. Otherwise period <= cnt+1, ovf<=0.
- Output handshake:
  - Result registered; period_valid rises on the edge after the capture cycle, i.e. 1-cycle latency.
  - Transfer occurs when period_valid & period_ready. period_valid falls next edge unless a new capture occurs.
  - Capture while period_valid=1 and period_ready=0: overwrite period/ovf, set dropped=1.
  - Capture while period_valid=1 and period_ready=1: new result loaded, period_valid stays 1, dropped cleared.
  - dropped is sticky until its result transfers; it clears with the transfer.
  - period/ovf are stable while period_valid=1 and not accepted, except on overwrite.
- busy = (state != IDLE).
- Reset mid-measurement aborts immediately to reset values. No partial result is emitted.

Optional Feature:
Macro PULSE_PERIOD_METER_EDGE_EN.
- Defined: pulse_in is treated as a level. Pulse event = rising edge, detected with a 1-flop history cleared to 0 on reset. A level held high for N cycles counts once.
- Undefined: every cycle with pulse_in=1 is a pulse event. A level held high N cycles yields N-1 results of period=1.

Decomposition:
- Package pulse_meter_pkg:
  - state typedef {IDLE, WAIT_FIRST, MEASURE}, 2-bit encoding
  - default CNT_W constant
  - function for saturated max value
- One sub-module pulse_edge_det (1-bit rising-edge detector, clk/rst async active-low). Instantiated only under PULSE_PERIOD_METER_EDGE_EN.

Test Plan:
- CNT_W=8, enable=1, 1-cycle pulses every 10 cycles, period_ready=1 -> first pulse gives no result; then period=10, ovf=0, period_valid high 1 cycle each 10 cycles, dropped=0.
- Back-to-back pulses on 3 consecutive cycles -> two results of period=1. Edge macro undefined; pulse as 1-cycle strobes.
- CNT_W=8, pulses 300 cycles apart -> period=255, ovf=1. Next gap 20 -> period=20, ovf=0.
- period_ready=0, pulses every 5 cycles -> second capture overwrites with dropped=1, period_valid stays 1. Raise ready -> transfer with period=5, dropped=1. Next result has dropped=0.
- enable dropped mid-MEASURE after 7 cycles, re-enabled -> returns to WAIT_FIRST. First pulse after re-enable gives no result; next gap of 12 -> period=12.
- rst asserted asynchronously mid-count with period_valid=1 -> all outputs 0 immediately. After release, IDLE and busy=0. With edge macro defined, pulse_in held high 6 cycles from WAIT_FIRST counts as one pulse only.
